// File: rtl/memoria_principal_resp.sv
// Next-level memory responder for the L2 cache.
// Requests arrive on Push/D_Push and wait in a small FIFO. Each request is
// serviced against a block-organised RAM with a fixed latency. Read data is
// returned on D_POP; PNDNG flags it until the cache acknowledges with Pop.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   Push, D_Push  request strobe and payload {R_W, addr[23:0], data[63:0]}
//   Pop           response acknowledge
//   D_POP         {addr[23:0], block[63:0]} of the last read
//   PNDNG         response valid, waiting for Pop
//   Full          request FIFO full
//   Overflow      sticky flag: a push was dropped while the FIFO was full
module memoria_principal_resp #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_BLOCKS = 256,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Push,
  input  logic [88:0] D_Push,
  input  logic        Pop,
  output logic [87:0] D_POP,
  output logic        PNDNG,
  output logic        Full,
  output logic        Overflow
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(MEM_BLOCKS);
  localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef struct packed {
    logic              r_w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  req_t                      fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0]         ram_q  [MEM_BLOCKS];

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  req_t                      req_q, req_d;
  logic [ADDR_W+DATA_W-1:0]  d_pop_q, d_pop_d;
  logic                      pndng_q, pndng_d;
  logic                      full_q, full_d;
  logic                      overflow_q, overflow_d;

  logic                      enq;
  logic                      deq;
  logic                      ram_we;
  logic [IDX_W-1:0]          ram_idx;

  assign D_POP    = d_pop_q;
  assign PNDNG    = pndng_q;
  assign Full     = full_q;
  assign Overflow = overflow_q;

  // Request FIFO bookkeeping; dequeue only happens from IDLE.
  always_comb begin
    enq        = Push && (count_q != CNT_W'(FIFO_DEPTH));
    deq        = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d   = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (enq && !deq)      count_d = count_q + CNT_W'(1);
    else if (!enq && deq) count_d = count_q - CNT_W'(1);
    full_d     = (count_d == CNT_W'(FIFO_DEPTH));
    // Dropped push: strobe seen while the registered count says full.
    overflow_d = overflow_q || (Push && !enq);
  end

  // Block index drops the byte offset; upper address bits alias.
  assign ram_idx = req_q.addr[IDX_W+2:3];
  assign ram_we  = (state_q == BUSY) && (lat_q == '0) && req_q.r_w;

  // Service FSM: fetch head, count out the latency, then write or respond.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    req_d   = req_q;
    d_pop_d = d_pop_q;
    pndng_d = pndng_q;
    unique case (state_q)
      IDLE: begin
        if (deq) begin
          req_d   = fifo_q[rd_ptr_q];
          lat_d   = LAT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_W'(1);
        end else if (req_q.r_w) begin
          state_d = IDLE;
        end else begin
          d_pop_d = {req_q.addr, ram_q[ram_idx]};
          pndng_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (Pop) begin
          pndng_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Control and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lat_q      <= '0;
      req_q      <= '0;
      d_pop_q    <= '0;
      pndng_q    <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lat_q      <= lat_d;
      req_q      <= req_d;
      d_pop_q    <= d_pop_d;
      pndng_q    <= pndng_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; no reset needed, validity is tracked by count_q.
  always_ff @(posedge CLK) begin
    if (!RST && enq) fifo_q[wr_ptr_q] <= D_Push;
  end

  // Backing RAM keeps its contents across reset; reset aborts a pending write.
  always_ff @(posedge CLK) begin
    if (!RST && ram_we) ram_q[ram_idx] <= req_q.data;
  end

endmodule

// File: tb/tb_memoria_principal_resp.sv
// Self-checking bench for memoria_principal_resp with a queue/array model.
module tb_memoria_principal_resp;

  localparam int unsigned LAT = 4;

  logic        CLK;
  logic        RST;
  logic        Push;
  logic [88:0] D_Push;
  logic        Pop;
  logic [87:0] D_POP;
  logic        PNDNG;
  logic        Full;
  logic        Overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] model_mem [256];
  logic [87:0] exp_q [$];

  memoria_principal_resp #(
    .FIFO_DEPTH(4),
    .MEM_BLOCKS(256),
    .LATENCY(LAT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Push(Push),
    .D_Push(D_Push),
    .Pop(Pop),
    .D_POP(D_POP),
    .PNDNG(PNDNG),
    .Full(Full),
    .Overflow(Overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mk_addr(input logic [7:0] blk);
    logic [12:0] hi;
    logic [2:0]  lo;
    hi = 13'($urandom);
    lo = 3'($urandom);
    return {hi, blk, lo};
  endfunction

  // One-cycle push; called and returns at a negedge.
  task automatic push_req(input logic rw, input logic [23:0] addr, input logic [63:0] data);
    Push   = 1'b1;
    D_Push = {rw, addr, data};
    @(negedge CLK);
    Push   = 1'b0;
  endtask

  task automatic write_blk(input logic [23:0] addr, input logic [63:0] data);
    push_req(1'b1, addr, data);
    model_mem[addr[10:3]] = data;
    repeat (LAT + 3) @(negedge CLK);
  endtask

  task automatic wait_pndng(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (PNDNG === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic pop_resp(output bit got, output logic [87:0] data);
    wait_pndng(got);
    data = D_POP;
    if (got) begin
      Pop = 1'b1;
      @(negedge CLK);
      Pop = 1'b0;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++; if (D_POP !== 88'h0) $display("FAIL reset_d_pop: got %h exp 0", D_POP); else n_pass++;
    n_checks++; if (PNDNG !== 1'b0) $display("FAIL reset_pndng: got %b exp 0", PNDNG); else n_pass++;
    n_checks++; if (Full !== 1'b0) $display("FAIL reset_full: got %b exp 0", Full); else n_pass++;
    n_checks++; if (Overflow !== 1'b0) $display("FAIL reset_overflow: got %b exp 0", Overflow); else n_pass++;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write_read;
    bit got;
    logic [87:0] d;
    push_req(1'b1, 24'h000010, 64'hDEADBEEF_01234567);
    model_mem[8'h02] = 64'hDEADBEEF_01234567;
    push_req(1'b0, 24'h000010, 64'h0);
    pop_resp(got, d);
    n_checks++; if (!got) $display("FAIL wr_rd_timeout: no response within bound"); else n_pass++;
    n_checks++; if (d !== {24'h000010, 64'hDEADBEEF_01234567})
      $display("FAIL wr_rd_data: got %h exp %h", d, {24'h000010, 64'hDEADBEEF_01234567}); else n_pass++;
    n_checks++; if (PNDNG !== 1'b0) $display("FAIL wr_rd_pop_drop: got %b exp 0", PNDNG); else n_pass++;
  endtask

  task automatic test_latency;
    bit got;
    logic [87:0] d;
    Push   = 1'b1;
    D_Push = {1'b0, 24'h000010, 64'h0};
    @(posedge CLK);
    for (int k = 0; k <= int'(LAT); k++) begin
      @(negedge CLK);
      Push = 1'b0;
      n_checks++; if (PNDNG !== 1'b0) $display("FAIL latency_low_edge_t+%0d: got %b exp 0", k, PNDNG); else n_pass++;
      if (k < int'(LAT)) @(posedge CLK);
    end
    @(negedge CLK);
    n_checks++; if (PNDNG !== 1'b1) $display("FAIL latency_high_edge_t+%0d: got %b exp 1", LAT + 1, PNDNG); else n_pass++;
    n_checks++; if (D_POP !== {24'h000010, 64'hDEADBEEF_01234567})
      $display("FAIL latency_data: got %h exp %h", D_POP, {24'h000010, 64'hDEADBEEF_01234567}); else n_pass++;
    pop_resp(got, d);
  endtask

  task automatic test_overflow;
    bit got;
    logic [87:0] d;
    logic [23:0] a [5];
    for (int i = 0; i < 5; i++) begin
      a[i] = mk_addr(8'(8'h40 + i));
      write_blk(a[i], {$urandom, $urandom});
    end
    exp_q.delete();
    push_req(1'b0, a[0], 64'h0);
    exp_q.push_back({a[0], model_mem[a[0][10:3]]});
    @(negedge CLK);
    for (int i = 1; i < 5; i++) begin
      push_req(1'b0, a[i], 64'h0);
      exp_q.push_back({a[i], model_mem[a[i][10:3]]});
    end
    n_checks++; if (Full !== 1'b1) $display("FAIL ovf_full: got %b exp 1", Full); else n_pass++;
    n_checks++; if (Overflow !== 1'b0) $display("FAIL ovf_not_yet: got %b exp 0", Overflow); else n_pass++;
    push_req(1'b0, mk_addr(8'h40), 64'h0);
    n_checks++; if (Overflow !== 1'b1) $display("FAIL ovf_set: got %b exp 1", Overflow); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      pop_resp(got, d);
      n_checks++; if (!got) $display("FAIL ovf_resp%0d_timeout: no response", i); else n_pass++;
      n_checks++; if (d !== exp_q[i]) $display("FAIL ovf_resp%0d: got %h exp %h", i, d, exp_q[i]); else n_pass++;
    end
    repeat (15) @(negedge CLK);
    n_checks++; if (PNDNG !== 1'b0) $display("FAIL ovf_no_extra_resp: got %b exp 0", PNDNG); else n_pass++;
    n_checks++; if (Full !== 1'b0) $display("FAIL ovf_full_clear: got %b exp 0", Full); else n_pass++;
    n_checks++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", Overflow); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_alias;
    bit got;
    logic [87:0] d;
    logic [63:0] db;
    db = {$urandom, $urandom};
    write_blk(24'h000008, {$urandom, $urandom});
    write_blk(24'h000808, db);
    push_req(1'b0, 24'h000008, 64'h0);
    pop_resp(got, d);
    n_checks++; if (!got) $display("FAIL alias_timeout: no response"); else n_pass++;
    n_checks++; if (d !== {24'h000008, db}) $display("FAIL alias_data: got %h exp %h", d, {24'h000008, db}); else n_pass++;
  endtask

  task automatic test_hold;
    bit got;
    bit stable;
    logic [87:0] cap;
    Pop = 1'b1;
    repeat (3) @(negedge CLK);
    push_req(1'b0, 24'h000010, 64'h0);
    repeat (2) @(negedge CLK);
    Pop = 1'b0;
    wait_pndng(got);
    cap = D_POP;
    n_checks++; if (!got) $display("FAIL hold_timeout: no response"); else n_pass++;
    n_checks++; if (cap !== {24'h000010, model_mem[8'h02]})
      $display("FAIL hold_data: got %h exp %h", cap, {24'h000010, model_mem[8'h02]}); else n_pass++;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (PNDNG !== 1'b1 || D_POP !== cap) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL hold_stable: got %b exp 1", stable); else n_pass++;
    n_checks++; if (Overflow !== 1'b1) $display("FAIL hold_overflow_sticky: got %b exp 1", Overflow); else n_pass++;
    Pop = 1'b1;
    @(negedge CLK);
    Pop = 1'b0;
    n_checks++; if (PNDNG !== 1'b0) $display("FAIL hold_pop_drop: got %b exp 0", PNDNG); else n_pass++;
    n_checks++; if (D_POP !== cap) $display("FAIL hold_dpop_keep: got %h exp %h", D_POP, cap); else n_pass++;
  endtask

  task automatic test_reset_busy;
    bit got;
    logic [87:0] d;
    write_blk(24'h000020, 64'h5);
    push_req(1'b1, 24'h000020, 64'h1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++; if (D_POP !== 88'h0) $display("FAIL rstbusy_d_pop: got %h exp 0", D_POP); else n_pass++;
    n_checks++; if (PNDNG !== 1'b0) $display("FAIL rstbusy_pndng: got %b exp 0", PNDNG); else n_pass++;
    n_checks++; if (Full !== 1'b0) $display("FAIL rstbusy_full: got %b exp 0", Full); else n_pass++;
    n_checks++; if (Overflow !== 1'b0) $display("FAIL rstbusy_overflow: got %b exp 0", Overflow); else n_pass++;
    push_req(1'b0, 24'h000020, 64'h0);
    pop_resp(got, d);
    n_checks++; if (!got) $display("FAIL rstbusy_timeout: no response"); else n_pass++;
    n_checks++; if (d !== {24'h000020, 64'h5}) $display("FAIL rstbusy_ram_kept: got %h exp %h", d, {24'h000020, 64'h5}); else n_pass++;
  endtask

  task automatic test_random;
    int pushed;
    int cyc;
    logic rw;
    logic [7:0] blk;
    logic [23:0] a;
    logic [63:0] dat;
    logic [87:0] e;
    for (int b = 0; b < 8; b++) write_blk(mk_addr(8'(b)), {$urandom, $urandom});
    exp_q.delete();
    pushed = 0;
    cyc = 0;
    while ((pushed < 60 || exp_q.size() > 0) && cyc < 4000) begin
      Pop  = 1'b0;
      Push = 1'b0;
      if (PNDNG === 1'b1 && $urandom_range(0, 2) != 0) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_unexpected_resp: got %h exp none", D_POP);
        else begin
          e = exp_q.pop_front();
          if (D_POP !== e) $display("FAIL rand_resp: got %h exp %h", D_POP, e); else n_pass++;
        end
        Pop = 1'b1;
      end
      if (pushed < 60 && Full === 1'b0 && $urandom_range(0, 1) == 1) begin
        rw  = 1'($urandom);
        blk = 8'($urandom_range(0, 7));
        a   = mk_addr(blk);
        dat = {$urandom, $urandom};
        Push   = 1'b1;
        D_Push = {rw, a, dat};
        if (rw) model_mem[blk] = dat;
        else    exp_q.push_back({a, model_mem[blk]});
        pushed++;
      end
      @(negedge CLK);
      cyc++;
    end
    Push = 1'b0;
    Pop  = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d outstanding exp 0", exp_q.size()); else n_pass++;
    repeat (30) @(negedge CLK);
    n_checks++; if (PNDNG !== 1'b0) $display("FAIL rand_idle_pndng: got %b exp 0", PNDNG); else n_pass++;
    n_checks++; if (Overflow !== 1'b0) $display("FAIL rand_overflow: got %b exp 0", Overflow); else n_pass++;
  endtask

  initial begin
    RST    = 1'b1;
    Push   = 1'b0;
    Pop    = 1'b0;
    D_Push = '0;
    @(negedge CLK);
    test_reset;
    test_write_read;
    test_latency;
    test_overflow;
    test_alias;
    test_hold;
    test_reset_busy;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memoria_principal_resp.md
Name: memoria_principal_resp

Overview:
- Downstream neighbour of the cache second level; the cache's next-level memory port.
- Consumes the cache's Push/D_Push request stream through a small request FIFO.
- Services each request against a block-organised backing RAM with a fixed access latency.
- Returns read blocks to the cache on D_POP, flagged by PNDNG and acknowledged by Pop.

Parameters:
FIFO_DEPTH, 4, request FIFO entries; power of two, >=2
MEM_BLOCKS, 256, number of 64-bit blocks in backing RAM; power of two
LATENCY, 4, service cycles per request; >=1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
Push  input  1  request strobe from cache; one request per cycle high
D_Push  input  89  [88]=R_W (1 write, 0 read), [87:64]=address, [63:0]=block data
Pop  input  1  cache acknowledges the current response
D_POP  output  88  [87:64]=request address echoed, [63:0]=block read
PNDNG  output  1  response valid and waiting for Pop
Full  output  1  request FIFO holds FIFO_DEPTH entries
Overflow  output  1  sticky: a Push was dropped because the FIFO was full

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset values:
  - D_POP=0, PNDNG=0, Full=0, Overflow=0.
  - FIFO count, pointers and latency counter cleared; FSM forced to IDLE.
  - RAM contents are not affected by RST.
- Reset mid-operation: an in-flight request is discarded with no RAM write, and a pending response is lost.
- Block index: address[log2(MEM_BLOCKS)+2:3]. Address bits [2:0] and bits above the index are ignored, so addresses alias.

Request FIFO:
- A Push with count<FIFO_DEPTH enqueues D_Push at the edge.
- Full = (count==FIFO_DEPTH), taken from the registered count.
- A Push while Full is dropped and sets Overflow at that edge, even if a dequeue occurs in the same cycle.
- Overflow clears only on RST.
- Simultaneous enqueue and dequeue leaves count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If count>0: dequeue the head into the request register, load cnt=LATENCY-1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt!=0: decrement cnt.
  - If cnt==0 and R_W=1: write D_Push[63:0] into RAM[index], go to IDLE. No response is produced.
  - If cnt==0 and R_W=0: load D_POP={addr, RAM[index]}, set PNDNG=1, go to RESP.
- RESP:
  - PNDNG holds at 1 and D_POP is stable until Pop=1.
  - At the Pop edge, PNDNG drops to 0 and the FSM goes to IDLE.
  - The next dequeue happens no earlier than the following edge.
  - D_POP keeps its last value after Pop.
- Pop while PNDNG=0 is ignored.

Timing:
- For a read pushed at edge t into an empty FIFO with FSM in IDLE, PNDNG rises at edge t+LATENCY+1.
- A write completes its RAM write at edge t+LATENCY+1.
- Ordering: requests are serviced strictly in FIFO order, so a read after a write to the same block returns the new data.
- Push continues to be accepted during BUSY and RESP while the FIFO is not Full.

Test Plan:
1. RST, then write {1,24'h000010,64'hDEADBEEF_01234567}, then read {0,24'h000010,x} -> PNDNG high with D_POP={24'h000010,64'hDEADBEEF_01234567}; Pop drops PNDNG next cycle.
2. Single read pushed at edge t into an idle block with LATENCY=4 -> PNDNG low through edge t+4, high from edge t+5.
3. Push 5 reads back-to-back with FIFO_DEPTH=4 while the FSM is BUSY -> Full=1 after the 4th; 5th dropped; Overflow=1 and stays 1 until RST; exactly 4 responses in push order.
4. Write addresses 0x000008 and 0x000808 (alias with MEM_BLOCKS=256), then read 0x000008 -> returns the data of the 0x000808 write.
5. Read response held with Pop=0 for 20 cycles -> PNDNG and D_POP stable; Pop with PNDNG=0 beforehand has no effect.
6. Assert RST during BUSY of a write to 0x000020 holding 64'h1 (RAM previously 64'h5) -> all outputs 0 next edge; a later read of 0x000020 returns 64'h5.
